// File: rtl/tape_playback_ctrl.sv
// -----------------------------------------------------------------------------
// tape_playback_ctrl
// Shares the cassette-image RAM between the downloader (writes .CAS bytes) and
// the playback engine (reads bytes and serialises them MSB-first). Each bit
// cell is a sync pulse followed by an optional data pulse on tape_bit, which
// the CPU reads through port $FF. Cell timing counts CPU clock enables (ce).
//
// Ports
//   clock, reset      master clock (posedge), asynchronous active-low reset
//   ce                CPU cycle enable, one clock wide
//   dn_go/dn_wr       download session active / byte write strobe
//   dn_addr/dn_data   download byte address / data
//   tape_play         user play request (level)
//   port_wr/port_rd   CPU write/read of $FF, qualified by ce
//   port_d            CPU write data: [2]=motor, [1:0]=output level
//   ram_a/ram_d/ram_we RAM address, write data, write enable
//   ram_q             RAM read data, valid one clock after ram_a
//   tape_bit          cassette input latch ($FF bit 0)
//   tape_lvl/motor    latched output level and motor bit
//   busy/at_end       playback active (FETCH/BIT) / end of image reached
// -----------------------------------------------------------------------------
module tape_playback_ctrl #(
    parameter int AW       = 17,
    parameter int SYNC_LEN = 512,
    parameter int DATA_AT  = 1791,
    parameter int DATA_LEN = 512,
    parameter int CELL     = 3593
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          dn_go,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [7:0]    dn_data,
    input  logic          tape_play,
    input  logic          port_wr,
    input  logic          port_rd,
    input  logic [2:0]    port_d,
    output logic [AW-1:0] ram_a,
    output logic [7:0]    ram_d,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          tape_bit,
    output logic [1:0]    tape_lvl,
    output logic          motor,
    output logic          busy,
    output logic          at_end
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_BIT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [11:0]   SYNC_END_C  = 12'(SYNC_LEN);
    localparam logic [11:0]   DATA_AT_C   = 12'(DATA_AT);
    localparam logic [11:0]   DATA_END_C  = 12'(DATA_AT + DATA_LEN);
    localparam logic [11:0]   CELL_LAST_C = 12'(CELL - 1);
    localparam logic [AW-1:0] PTR_ONE_C   = AW'(1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] end_addr_q, end_addr_d;
    logic          loaded_q, loaded_d;
    logic [11:0]   cnt_q, cnt_d;
    logic [2:0]    bitptr_q, bitptr_d;
    logic [7:0]    byte_q, byte_d;
    logic          bitval_q, bitval_d;
    logic          fetch2_q, fetch2_d;
    logic          play_prev_q, play_prev_d;
    logic          tape_bit_q, tape_bit_d;
    logic [1:0]    tape_lvl_q, tape_lvl_d;
    logic          motor_q, motor_d;
    logic          busy_q, busy_d;
    logic          at_end_q, at_end_d;

    logic          ce_rd_s, ce_wr_s, motor_rise_s, motor_fall_s;
    logic          set_s, clr_s;

    assign ce_rd_s      = port_rd & ce;
    assign ce_wr_s      = port_wr & ce;
    assign motor_rise_s = ce_wr_s & port_d[2] & ~motor_q;
    assign motor_fall_s = ce_wr_s & ~port_d[2] & motor_q;

    // RAM port arbitration: the downloader owns the RAM for the whole session.
    // The write strobe is also gated by reset so no write escapes mid-reset.
    assign ram_a  = dn_go ? dn_addr : ptr_q;
    assign ram_d  = dn_data;
    assign ram_we = dn_go & dn_wr & reset;

    assign tape_bit = tape_bit_q;
    assign tape_lvl = tape_lvl_q;
    assign motor    = motor_q;
    assign busy     = busy_q;
    assign at_end   = at_end_q;

    // Next-state logic: sequencer, bit-cell timing, latch and CPU port handling.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        end_addr_d  = end_addr_q;
        loaded_d    = loaded_q;
        cnt_d       = cnt_q;
        bitptr_d    = bitptr_q;
        byte_d      = byte_q;
        bitval_d    = bitval_q;
        fetch2_d    = fetch2_q;
        play_prev_d = tape_play;
        tape_bit_d  = tape_bit_q;
        tape_lvl_d  = tape_lvl_q;
        motor_d     = motor_q;
        set_s       = 1'b0;
        clr_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((tape_play || (ce_rd_s && motor_q)) && loaded_q) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // First clock presents ptr; ram_q is valid on the second.
                if (fetch2_q) begin
                    byte_d   = ram_q;
                    bitptr_d = 3'd7;
                    cnt_d    = 12'd0;
                    state_d  = S_BIT;
                end else begin
                    fetch2_d = 1'b1;
                end
            end
            S_BIT: begin
                if (ce) begin
                    if (cnt_q < SYNC_END_C) begin
                        set_s = 1'b1;
                    end else if ((cnt_q > DATA_AT_C) && (cnt_q < DATA_END_C) && bitval_q) begin
                        set_s = 1'b1;
                    end else begin
                        set_s = 1'b0;
                    end
                    // Trailing edges of the sync and data windows drop the latch.
                    if ((cnt_q == SYNC_END_C) || (cnt_q == DATA_END_C)) begin
                        clr_s = 1'b1;
                    end else begin
                        clr_s = 1'b0;
                    end
                    if (cnt_q == DATA_AT_C) begin
                        bitval_d = byte_q[bitptr_q];
                    end else begin
                        bitval_d = bitval_q;
                    end
                    if (cnt_q == CELL_LAST_C) begin
                        cnt_d = 12'd0;
                        if (bitptr_q == 3'd0) begin
                            ptr_d   = ptr_q + PTR_ONE_C;
                            state_d = (ptr_q == end_addr_q) ? S_DONE : S_FETCH;
                        end else begin
                            bitptr_d = bitptr_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 12'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE: begin
                if (play_prev_q && !tape_play) begin
                    state_d = S_IDLE;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ce_wr_s) begin
            motor_d    = port_d[2];
            tape_lvl_d = port_d[1:0];
        end else begin
            motor_d    = motor_q;
            tape_lvl_d = tape_lvl_q;
        end

        // Motor start rewinds to the image start; motor stop keeps the
        // position so a later start re-fetches the current byte from bit 7.
        if (motor_rise_s) begin
            state_d  = S_IDLE;
            ptr_d    = {AW{1'b0}};
            bitptr_d = 3'd7;
        end else if (motor_fall_s) begin
            state_d = S_IDLE;
            if (state_q == S_DONE) begin
                ptr_d = {AW{1'b0}};
            end else begin
                ptr_d = ptr_d;
            end
        end else begin
            state_d = state_d;
        end

        // A CPU access clears the latch, but a set in the same ce wins.
        if (set_s) begin
            tape_bit_d = 1'b1;
        end else if (clr_s || ce_rd_s || ce_wr_s) begin
            tape_bit_d = 1'b0;
        end else begin
            tape_bit_d = tape_bit_q;
        end

        // A download session overrides everything on the playback side.
        if (dn_go) begin
            state_d    = S_IDLE;
            ptr_d      = {AW{1'b0}};
            tape_bit_d = 1'b0;
            if (dn_wr) begin
                end_addr_d = dn_addr;
                loaded_d   = 1'b1;
            end else begin
                end_addr_d = end_addr_q;
            end
        end else begin
            loaded_d = loaded_q;
        end

        if (state_d != S_FETCH) begin
            fetch2_d = 1'b0;
        end else begin
            fetch2_d = fetch2_d;
        end

        busy_d   = (state_d == S_FETCH) || (state_d == S_BIT);
        at_end_d = (state_d == S_DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= {AW{1'b0}};
            end_addr_q  <= {AW{1'b0}};
            loaded_q    <= 1'b0;
            cnt_q       <= 12'd0;
            bitptr_q    <= 3'd7;
            byte_q      <= 8'd0;
            bitval_q    <= 1'b0;
            fetch2_q    <= 1'b0;
            play_prev_q <= 1'b0;
            tape_bit_q  <= 1'b0;
            tape_lvl_q  <= 2'd0;
            motor_q     <= 1'b0;
            busy_q      <= 1'b0;
            at_end_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            end_addr_q  <= end_addr_d;
            loaded_q    <= loaded_d;
            cnt_q       <= cnt_d;
            bitptr_q    <= bitptr_d;
            byte_q      <= byte_d;
            bitval_q    <= bitval_d;
            fetch2_q    <= fetch2_d;
            play_prev_q <= play_prev_d;
            tape_bit_q  <= tape_bit_d;
            tape_lvl_q  <= tape_lvl_d;
            motor_q     <= motor_d;
            busy_q      <= busy_d;
            at_end_q    <= at_end_d;
        end
    end

endmodule

// File: tb/tb_tape_playback_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tape_playback_ctrl
// Scoreboard bench. Stimulus pushes expected output snapshots and expected
// bit-cell values into queues; a forked monitor pops and compares them.
// Cell timing is shrunk (SYNC 8, DATA_AT 30, DATA_LEN 6, CELL 40) with ce
// every 4 clocks so that a whole three-byte image plays quickly.
// -----------------------------------------------------------------------------
module tb_tape_playback_ctrl;

    localparam int AW  = 17;
    localparam int SL  = 8;
    localparam int DA  = 30;
    localparam int DL  = 6;
    localparam int CL  = 40;
    localparam int CEP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ce;
    logic          dn_go = 1'b0;
    logic          dn_wr = 1'b0;
    logic [AW-1:0] dn_addr = '0;
    logic [7:0]    dn_data = 8'h00;
    logic          tape_play = 1'b0;
    logic          port_wr = 1'b0;
    logic          port_rd = 1'b0;
    logic [2:0]    port_d = 3'b000;
    logic [AW-1:0] ram_a;
    logic [7:0]    ram_d;
    logic          ram_we;
    logic [7:0]    ram_q = 8'h00;
    logic          tape_bit;
    logic [1:0]    tape_lvl;
    logic          motor;
    logic          busy;
    logic          at_end;

    tape_playback_ctrl #(
        .AW(AW), .SYNC_LEN(SL), .DATA_AT(DA), .DATA_LEN(DL), .CELL(CL)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce),
        .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .tape_play(tape_play), .port_wr(port_wr), .port_rd(port_rd), .port_d(port_d),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .tape_bit(tape_bit), .tape_lvl(tape_lvl), .motor(motor),
        .busy(busy), .at_end(at_end)
    );

    always #5 clock = ~clock;

    logic [1:0]  ce_div = 2'd0;
    int unsigned cyc = 0;
    always @(posedge clock) begin
        ce_div <= ce_div + 2'd1;
        cyc    <= cyc + 1;
    end
    assign ce = (ce_div == 2'd3);

    // Synchronous RAM model with one clock read latency.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    typedef struct {
        string       name;
        logic [23:0] exp;
    } snap_t;

    snap_t      snap_q[$];
    bit         cell_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cell_idx = 0;
    bit         mon_en = 1'b0;
    logic [7:0] img [0:2];

    function automatic logic [23:0] pack_out();
        return {ram_a, ram_we, tape_bit, tape_lvl, motor, busy, at_end};
    endfunction

    task automatic expect_out(input string nm, input logic [AW-1:0] a, input logic we,
                              input logic tb_v, input logic [1:0] lvl, input logic m,
                              input logic b, input logic e);
        snap_t s;
        s.name = nm;
        s.exp  = {a, we, tb_v, lvl, m, b, e};
        snap_q.push_back(s);
        @(negedge clock);
        #1;
    endtask

    task automatic cell_emit(input bit v);
        bit e;
        checks++;
        if (cell_q.size() == 0) begin
            errors++;
            $display("FAIL cell_extra[%0d]: got bit %0b, required no cell", cell_idx, v);
        end else begin
            e = cell_q.pop_front();
            if (v !== e) begin
                errors++;
                $display("FAIL cell_bit[%0d]: got %0b, required %0b", cell_idx, v, e);
            end
        end
        cell_idx++;
    endtask

    task automatic chk_eq(input string nm, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Monitor: compares snapshots and decodes tape_bit into bit cells.
    task automatic run_monitor();
        snap_t       s;
        logic [23:0] act;
        bit          prev_tb = 1'b0, prev_end = 1'b0, have_cell = 1'b0;
        bit          cur_data = 1'b0, sync_valid = 1'b0;
        int unsigned rise_t = 0, last_sync = 0, len;
        forever begin
            @(negedge clock);
            if (snap_q.size() != 0) begin
                s   = snap_q.pop_front();
                act = pack_out();
                checks++;
                if (act !== s.exp) begin
                    errors++;
                    $display("FAIL %s: got {a,we,bit,lvl,m,busy,end}=%h, required %h",
                             s.name, act, s.exp);
                end
            end
            if (!mon_en) begin
                prev_tb = 1'b0; prev_end = 1'b0; have_cell = 1'b0; sync_valid = 1'b0;
            end else begin
                if (tape_bit && !prev_tb) rise_t = cyc;
                if (!tape_bit && prev_tb) begin
                    len = cyc - rise_t;
                    if (len >= (SL * CEP + (DL - 1) * CEP) / 2) begin
                        chk_eq("sync_len_clk", len, SL * CEP);
                        if (sync_valid) chk_eq("cell_period_clk", rise_t - last_sync, CL * CEP);
                        if (have_cell) cell_emit(cur_data);
                        have_cell  = 1'b1;
                        cur_data   = 1'b0;
                        last_sync  = rise_t;
                        sync_valid = 1'b1;
                    end else begin
                        chk_eq("data_len_clk", len, (DL - 1) * CEP);
                        chk_eq("data_offset_clk", rise_t - last_sync, (DA + 1) * CEP);
                        cur_data = 1'b1;
                    end
                end
                if (at_end && !prev_end && have_cell) begin
                    cell_emit(cur_data);
                    have_cell  = 1'b0;
                    sync_valid = 1'b0;
                end
                prev_tb  = tape_bit;
                prev_end = at_end;
            end
        end
    endtask

    function automatic bit cond(input int w);
        case (w)
            0:       return tape_bit;
            1:       return !tape_bit;
            2:       return at_end;
            3:       return (ram_a == 17'd1) && busy;
            4:       return ce;
            default: return 1'b1;
        endcase
    endfunction

    task automatic wait_until(input string nm, input int w, input int maxc);
        int i = 0;
        bit ok;
        ok = cond(w);
        while (!ok && i < maxc) begin
            @(posedge clock);
            #1;
            i++;
            ok = cond(w);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s: condition not reached, got timeout, required within %0d clocks", nm, maxc);
        end
    endtask

    task automatic skip_ce(input int n);
        repeat (n) begin
            wait_until("ce_wait", 4, 8);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_ce_pulse(input logic rd, input logic wr, input logic [2:0] d);
        wait_until("ce_wait", 4, 8);
        port_rd = rd;
        port_wr = wr;
        port_d  = d;
        @(posedge clock);
        #1;
        port_rd = 1'b0;
        port_wr = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) cell_q.push_back(v[b]);
    endtask

    task automatic chk_cells_drained(input string nm);
        checks++;
        if (cell_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d cells outstanding, required 0", nm, cell_q.size());
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        img[0] = 8'hA5; img[1] = 8'h00; img[2] = 8'hFF;

        repeat (3) @(posedge clock);
        #1;
        expect_out("reset_state", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // No image loaded yet: play request must be ignored.
        tape_play = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        expect_out("no_image_no_start", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tape_play = 1'b0;

        // Download A5,00,FF at addresses 0..2.
        dn_go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dn_addr = AW'(i);
            dn_data = img[i];
            dn_wr   = 1'b1;
            expect_out($sformatf("dn_write%0d", i), AW'(i), 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
            @(posedge clock);
            #1;
        end
        dn_wr   = 1'b0;
        dn_addr = 17'h1F0F0;
        expect_out("dn_addr_passthru", 17'h1F0F0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        dn_go = 1'b0;
        expect_out("ptr_after_dn", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Full playback of the three bytes.
        for (int i = 0; i < 3; i++) push_byte(img[i]);
        mon_en    = 1'b1;
        tape_play = 1'b1;
        @(posedge clock);
        #1;
        expect_out("fetch_started", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        wait_until("first_sync", 0, 50);
        skip_ce(2);
        do_ce_pulse(1'b1, 1'b0, 3'b000);
        expect_out("rd_in_sync_set_wins", 17'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
        skip_ce(11);
        do_ce_pulse(1'b1, 1'b0, 3'b000);
        expect_out("rd_in_gap_clears", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        wait_until("reach_end", 2, 24 * CL * CEP + 200);
        expect_out("done_state", 17'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        repeat (2 * CL * CEP) @(posedge clock);
        #1;
        expect_out("done_holds", 17'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tape_play = 1'b0;
        @(posedge clock);
        #1;
        expect_out("done_to_idle", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk_cells_drained("cells_full_image");

        // Replay, then abort with dn_go once byte 1 has started.
        push_byte(img[0]);
        tape_play = 1'b1;
        wait_until("ptr1_fetch", 3, 8 * CL * CEP + 100);
        wait_until("ptr1_sync_rise", 0, 50);
        wait_until("ptr1_sync_fall", 1, CL * CEP);
        @(negedge clock);
        #1;
        mon_en    = 1'b0;
        dn_go     = 1'b1;
        dn_addr   = 17'h0ABCD;
        tape_play = 1'b0;
        @(posedge clock);
        #1;
        expect_out("dn_go_abort", 17'h0ABCD, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk_cells_drained("cells_byte0_replay");
        dn_go = 1'b0;
        @(posedge clock);
        #1;
        expect_out("ptr_zero_after_abort", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        // Motor control and motor-started playback.
        do_ce_pulse(1'b0, 1'b1, 3'b110);
        expect_out("motor_on", 17'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        do_ce_pulse(1'b1, 1'b0, 3'b000);
        expect_out("rd_motor_start", 17'd0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
        wait_until("motor_ptr1", 3, 8 * CL * CEP + 100);
        wait_until("motor_sync_rise", 0, 50);
        wait_until("motor_sync_fall", 1, CL * CEP);
        do_ce_pulse(1'b0, 1'b1, 3'b000);
        expect_out("motor_off_holds_ptr", 17'd1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        do_ce_pulse(1'b0, 1'b1, 3'b100);
        expect_out("motor_on_resets_ptr", 17'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a sync pulse.
        tape_play = 1'b1;
        wait_until("reset_sync_rise", 0, 50);
        #1;
        reset = 1'b0;
        expect_out("async_reset_mid_cell", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tape_play = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        expect_out("after_reset_idle", 17'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
